// File: rtl/icache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the I-cache tag store.
// The helpers work on a 32-bit node vector so any NUM_WAY up to 32 fits.
package icache_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } sweep_state_e;

    localparam int PLRU_MAX_LVL = 5;

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    // A node bit of 0 steers the victim walk to the left child.
    function automatic int plru_victim(
        input logic [31:0] plru,
        input int          num_way
    );
        int node;
        int way;
        int lvls;
        int dir;
        lvls = $clog2(num_way);
        node = 0;
        way  = 0;
        for (int l = 0; l < PLRU_MAX_LVL; l++) begin
            if (l < lvls) begin
                dir  = plru[node[4:0]] ? 1 : 0;
                way  = way * 2 + dir;
                node = 2 * node + 1 + dir;
            end
        end
        return way;
    endfunction

    // Make every node on the path to 'way' point at the other subtree.
    function automatic logic [31:0] plru_update(
        input logic [31:0] plru,
        input int          way,
        input int          num_way
    );
        logic [31:0] nxt;
        int node;
        int lvls;
        int dir;
        nxt  = plru;
        lvls = $clog2(num_way);
        node = 0;
        for (int l = 0; l < PLRU_MAX_LVL; l++) begin
            if (l < lvls) begin
                dir = (way >> (lvls - 1 - l)) & 1;
                nxt[node[4:0]] = (dir == 0);
                node = 2 * node + 1 + dir;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state with clear-over-update priority.
// Ports: clk, rst (sync, active-high), update_i/update_way_i touch a way,
// clear_i resets the tree, victim_o is the way the tree points to.
module plru_tree
    import icache_pkg::*;
#(
    parameter int NUM_WAY   = 4,
    parameter int WAY_DEPTH = $clog2(NUM_WAY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 update_i,
    input  logic [WAY_DEPTH-1:0] update_way_i,
    input  logic                 clear_i,
    output logic [WAY_DEPTH-1:0] victim_o
);

    localparam int PW = NUM_WAY - 1;

    logic [PW-1:0] r_plru;
    logic [PW-1:0] w_plru_nxt;

    always_comb begin
        w_plru_nxt = PW'(plru_update(32'(r_plru), int'(update_way_i), NUM_WAY));
        victim_o   = WAY_DEPTH'(plru_victim(32'(r_plru), NUM_WAY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_plru <= '0;
        end else if (clear_i) begin
            r_plru <= '0;
        end else if (update_i) begin
            r_plru <= w_plru_nxt;
        end
    end

endmodule

// File: rtl/tag_access_icache_plru.sv
// N-way I-cache tag store: 1-cycle lookup, invalid-first/PLRU victim,
// per-set invalidate and a global invalidate sweep.
// Ports: r_req_* lookup (ready/valid), r_resp_valid_o/hit_o/wayid_hit_o
// response; w_req_* fill (ready/valid), w_victim_o fill way;
// inv_set_valid_i/inv_setid_i per-set invalidate; inv_all_i sweep; busy_o.
module tag_access_icache_plru
    import icache_pkg::*;
#(
    parameter int TAG_WIDTH = 7,
    parameter int NUM_SET   = 32,
    parameter int NUM_WAY   = 4,
    parameter int SET_DEPTH = $clog2(NUM_SET),
    parameter int WAY_DEPTH = $clog2(NUM_WAY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_req_valid_i,
    output logic                 r_req_ready_o,
    input  logic [SET_DEPTH-1:0] r_req_setid_i,
    input  logic [TAG_WIDTH-1:0] r_req_tag_i,
    output logic                 r_resp_valid_o,
    output logic                 hit_o,
    output logic [WAY_DEPTH-1:0] wayid_hit_o,
    input  logic                 w_req_valid_i,
    output logic                 w_req_ready_o,
    input  logic [SET_DEPTH-1:0] w_req_setid_i,
    input  logic [TAG_WIDTH-1:0] w_req_tag_i,
    output logic [WAY_DEPTH-1:0] w_victim_o,
    input  logic                 inv_set_valid_i,
    input  logic [SET_DEPTH-1:0] inv_setid_i,
    input  logic                 inv_all_i,
    output logic                 busy_o
);

    sweep_state_e r_state;
    sweep_state_e w_state_nxt;
    logic [SET_DEPTH-1:0] r_cnt;
    logic [SET_DEPTH-1:0] w_cnt_nxt;

    logic w_busy;
    logic w_rd_acc;
    logic w_fill_acc;
    logic w_inv_set;

    logic [NUM_WAY-1:0]   r_valid [NUM_SET];
    logic [TAG_WIDTH-1:0] r_tag   [NUM_SET][NUM_WAY];

    logic                 r_s1_valid;
    logic [SET_DEPTH-1:0] r_s1_set;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic [NUM_WAY-1:0]   r_s1_vbits;
    logic [TAG_WIDTH-1:0] r_s1_tags [NUM_WAY];

    logic                 w_hit;
    logic [WAY_DEPTH-1:0] w_hit_way;

    logic [WAY_DEPTH-1:0] w_tree_vic [NUM_SET];
    logic [NUM_WAY-1:0]   w_fill_vbits;
    logic [WAY_DEPTH-1:0] w_victim;
    logic                 w_free_found;

    logic [NUM_SET-1:0] w_set_clr;
    logic [NUM_SET-1:0] w_set_fill;
    logic [NUM_SET-1:0] w_set_hit;

    // Sweep FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (inv_all_i) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                if (r_cnt == SET_DEPTH'(NUM_SET - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_busy     = (r_state == ST_SWEEP);
    assign busy_o     = w_busy;
    assign r_req_ready_o = !w_busy;
    assign w_req_ready_o = !w_busy;
    assign w_rd_acc   = r_req_valid_i && !w_busy;
    assign w_fill_acc = w_req_valid_i && !w_busy;
    assign w_inv_set  = inv_set_valid_i && !w_busy;

    // Stage 0: capture the pre-edge row so a same-cycle fill is invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_set   <= '0;
            r_s1_tag   <= '0;
            r_s1_vbits <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_set   <= r_req_setid_i;
                r_s1_tag   <= r_req_tag_i;
                r_s1_vbits <= r_valid[r_req_setid_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                r_s1_tags[w] <= r_tag[r_req_setid_i][w];
            end
        end
    end

    // Stage 1: compare; several matches resolve to the lowest way.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAY; w++) begin
            if (r_s1_valid && !w_hit && r_s1_vbits[w] &&
                r_s1_tags[w] == r_s1_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_DEPTH'(w);
            end
        end
    end

    assign r_resp_valid_o = r_s1_valid;
    assign hit_o          = w_hit;
    assign wayid_hit_o    = w_hit_way;

    // Victim: lowest invalid way, else the PLRU pointer.
    always_comb begin
        w_fill_vbits = r_valid[w_req_setid_i];
        w_victim     = w_tree_vic[w_req_setid_i];
        w_free_found = 1'b0;
        for (int w = 0; w < NUM_WAY; w++) begin
            if (!w_free_found && !w_fill_vbits[w]) begin
                w_free_found = 1'b1;
                w_victim     = WAY_DEPTH'(w);
            end
        end
    end

    assign w_victim_o = w_victim;

    // Fill touch takes priority over a hit touch on the same set;
    // clearing (invalidate or sweep) beats both inside the tree.
    for (genvar s = 0; s < NUM_SET; s++) begin : g_set
        assign w_set_clr[s] =
            (w_busy && r_cnt == SET_DEPTH'(s)) ||
            (w_inv_set && inv_setid_i == SET_DEPTH'(s));
        assign w_set_fill[s] =
            w_fill_acc && w_req_setid_i == SET_DEPTH'(s);
        assign w_set_hit[s] =
            w_hit && r_s1_set == SET_DEPTH'(s);

        plru_tree #(
            .NUM_WAY   (NUM_WAY),
            .WAY_DEPTH (WAY_DEPTH)
        ) u_plru (
            .clk          (clk),
            .rst          (rst),
            .update_i     (w_set_fill[s] || w_set_hit[s]),
            .update_way_i (w_set_fill[s] ? w_victim : w_hit_way),
            .clear_i      (w_set_clr[s]),
            .victim_o     (w_tree_vic[s])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SET; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SET; s++) begin
                if (w_set_clr[s]) begin
                    r_valid[s] <= '0;
                end else if (w_set_fill[s]) begin
                    r_valid[s][w_victim] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_acc) begin
            r_tag[w_req_setid_i][w_victim] <= w_req_tag_i;
        end
    end

endmodule
